// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, a write-through writeback
// port and a per-register busy scoreboard feeding the decode-stage stall logic.
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_wa,
    input  logic             flush,
    output logic [AW:0]      nbusy
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      nbusy_q;
    logic [AW:0]      nbusy_d;

    logic wb_valid;
    logic iss_valid;
    logic wb_hit1;
    logic wb_hit2;

    assign wb_valid  = we3 && (wa3 != '0);
    assign iss_valid = iss_en && (iss_wa != '0);

    // Bypass and busy masking share one match so they can never disagree.
    assign wb_hit1 = wb_valid && (wa3 == ra1);
    assign wb_hit2 = wb_valid && (wa3 == ra2);

    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = wb_hit1 ? wd3 : mem_q[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = wb_hit2 ? wd3 : mem_q[ra2];
        end
    end

    assign busy1 = busy_q[ra1] && !wb_hit1;
    assign busy2 = busy_q[ra2] && !wb_hit2;

    // Order matters: flush, then writeback completion, then a new issue wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else if (wb_valid) begin
            busy_d[wa3] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_wa] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        nbusy_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            nbusy_d = nbusy_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q  <= '0;
            nbusy_q <= '0;
        end else begin
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_valid) begin
            mem_q[wa3] <= wd3;
        end
    end

    assign nbusy = nbusy_q;

endmodule
